// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding imem request at a time,
// buffers returned words in a small FIFO for decode, and flushes/restarts on execute redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_PC,
    output logic [31:0] if_instr,
    output logic        fetch_fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_pc;
    logic               kill;
    logic [31:0]        fifo_pc    [FIFO_DEPTH];
    logic [31:0]        fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;

    logic issue, push, pop, resp;

    // Request is masked during reset so every output except the address reads zero.
    assign imem_req  = !rst && (state == FETCH) && (count < CNT_W'(FIFO_DEPTH)) && !fetch_fault;
    assign imem_addr = fetch_pc;
    assign if_valid  = (count != '0);
    assign if_PC     = fifo_pc[rd_ptr];
    assign if_instr  = fifo_instr[rd_ptr];

    assign issue = imem_req && imem_gnt;
    assign resp  = (state == WAIT) && imem_rvalid;
    assign push  = resp && !kill && !redirect_valid;
    assign pop   = if_valid && if_ready && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (issue) state_next = WAIT;
            WAIT:  if (imem_rvalid) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // A redirect overrides everything; kill marks the one outstanding response as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            kill        <= 1'b0;
            fetch_fault <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_PC;
            fetch_fault <= |redirect_PC[1:0];
            kill        <= ((state == WAIT) && !imem_rvalid) || issue;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp && kill)
                kill <= 1'b0;
            if (push) begin
                fifo_pc[wr_ptr]    <= req_pc;
                fifo_instr[wr_ptr] <= imem_rdata;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one row per clock with inputs and hand-derived outputs.
module tb_fetch_unit;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvl;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic        chk_head;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_flt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_PC;
    logic [31:0] if_instr;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_PC(if_PC), .if_instr(if_instr),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic gnt, input logic rvl, input logic [31:0] rdata,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic chk, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic e_flt);
        vec_t v;
        v.rst = r;  v.rv = rv;  v.rpc = rpc;  v.gnt = gnt;  v.rvl = rvl;  v.rdata = rdata;
        v.rdy = rdy;  v.e_req = e_req;  v.e_addr = e_addr;  v.e_iv = e_iv;  v.chk_head = chk;
        v.e_pc = e_pc;  v.e_instr = e_instr;  v.e_flt = e_flt;
        return v;
    endfunction

    task automatic check32(input string name, input int row, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL row %0d %s got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        redirect_valid = v.rv;
        redirect_PC    = v.rpc;
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rvl;
        imem_rdata     = v.rdata;
        if_ready       = v.rdy;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        check32("imem_req", row, {31'b0, imem_req}, {31'b0, v.e_req});
        check32("imem_addr", row, imem_addr, v.e_addr);
        check32("if_valid", row, {31'b0, if_valid}, {31'b0, v.e_iv});
        check32("fetch_fault", row, {31'b0, fetch_fault}, {31'b0, v.e_flt});
        if (v.chk_head) begin
            check32("if_PC", row, if_PC, v.e_pc);
            check32("if_instr", row, if_instr, v.e_instr);
        end
    endtask

    initial begin
        rst = 1'b1;  redirect_valid = 1'b0;  redirect_PC = '0;  imem_gnt = 1'b0;
        imem_rvalid = 1'b0;  imem_rdata = '0;  if_ready = 1'b0;

        //        rst rv rpc            gnt rvl rdata          rdy  req addr          iv chk pc             instr          flt
        // reset state
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  0, 32'h0,        0, 1, 32'h0,        32'h0,         0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,         0,  0, 32'h0,        0, 1, 32'h0,        32'h0,         0));
        // streaming at one instruction per two cycles
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_0000, 1,  0, 32'h4,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h4,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_0004, 1,  0, 32'h8,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h8,        1, 1, 32'h4,        32'hC0DE_0004, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_0008, 1,  0, 32'hC,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'hC,        1, 1, 32'h8,        32'hC0DE_0008, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_000C, 1,  0, 32'h10,       0, 0, 32'h0,        32'h0,         0));
        // reset mid-stream clears immediately
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  0, 32'h0,        0, 1, 32'h0,        32'h0,         0));
        // decode stalled: two entries fill the buffer, then requests stop
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_0000, 0,  0, 32'h4,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  1, 32'h4,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'hC0DE_0004, 0,  0, 32'h8,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  0, 32'h8,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  0, 32'h8,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  0, 32'h8,        1, 1, 32'h0,        32'hC0DE_0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h8,        1, 1, 32'h4,        32'hC0DE_0004, 0));
        // redirect while waiting on PC 0x8: its response is dropped
        vecs.push_back(mk(0, 1, 32'h100,      0, 0, 32'h0,         1,  0, 32'hC,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_0008, 1,  0, 32'h100,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h100,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_0100, 1,  0, 32'h104,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h104,      1, 1, 32'h100,      32'hC0DE_0100, 0));
        // redirect coinciding with rvalid and a pop, one entry buffered plus one in flight
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  1, 32'h104,      1, 1, 32'h100,      32'hC0DE_0100, 0));
        vecs.push_back(mk(0, 1, 32'h200,      0, 1, 32'hC0DE_0104, 1,  0, 32'h108,      1, 1, 32'h100,      32'hC0DE_0100, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h200,      0, 0, 32'h0,        32'h0,         0));
        // misaligned redirect withdraws the pending request and faults
        vecs.push_back(mk(0, 1, 32'h102,      0, 0, 32'h0,         1,  1, 32'h200,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  0, 32'h102,      0, 0, 32'h0,        32'h0,         1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  0, 32'h102,      0, 0, 32'h0,        32'h0,         1));
        vecs.push_back(mk(0, 1, 32'h300,      1, 0, 32'h0,         1,  0, 32'h102,      0, 0, 32'h0,        32'h0,         1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h300,      0, 0, 32'h0,        32'h0,         0));
        // redirect in the same cycle as a grant: that response is dropped
        vecs.push_back(mk(0, 1, 32'h400,      1, 0, 32'h0,         1,  1, 32'h300,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_0300, 1,  0, 32'h400,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'h400,      0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_0400, 1,  0, 32'h404,      0, 0, 32'h0,        32'h0,         0));
        // reset while waiting with an entry buffered; late rvalid in FETCH ignored
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         0,  1, 32'h404,      1, 1, 32'h400,      32'hC0DE_0400, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,         0,  0, 32'h0,        0, 1, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF, 0,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        // fetch PC wraps past the top of the address space
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,        1,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC0DE_FFFC, 1,  0, 32'h0,        0, 0, 32'h0,        32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'hC0DE_FFFC, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1,  1, 32'h0,        0, 0, 32'h0,        32'h0,         0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
